// File: rtl/layer_frame_collector_pkg.sv
// Shared types and defaults for the layer frame collector slice.
package layer_pkg;

    localparam int T_DEF = 9;
    localparam int M_DEF = 5;

    typedef enum logic [0:0] {COLLECT, DRAIN} collector_state_t;

    typedef logic signed [T_DEF-1:0] word_t;

endpackage

// File: rtl/layer_frame_collector_if.sv
// Valid/ready word stream between layer blocks; last marks the final word of a frame.
interface layer_frame_collector_if
    import layer_pkg::*;
#(
    parameter int T = T_DEF
) ();
    logic                valid;
    logic                ready;
    logic signed [T-1:0] data;
    logic                last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/layer_frame_collector_argmax.sv
// Running signed maximum and its index over the words of one frame.
module frame_argmax
    import layer_pkg::*;
#(
    parameter int T    = T_DEF,
    parameter int LOGM = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                first,
    input  logic signed [T-1:0] din,
    input  logic [LOGM-1:0]     idx,
    output logic signed [T-1:0] max_val,
    output logic [LOGM-1:0]     max_idx
);

    // Strict greater-than so a tie keeps the earlier index.
    always_ff @(posedge clk) begin
        if (reset) begin
            max_val <= '0;
            max_idx <= '0;
        end else if (load && (first || (din > max_val))) begin
            max_val <= din;
            max_idx <= idx;
        end
    end

endmodule

// File: rtl/layer_frame_collector.sv
// Buffers one frame of M signed words with argmax, then replays it downstream with a last flag.
//   state   | meaning
//   COLLECT | s_ready high, words stored at wr_idx, running max updated
//   DRAIN   | m_valid/max_valid high, buffer replayed from rd_idx until last handshake
module layer_frame_collector
    import layer_pkg::*;
#(
    parameter int T    = T_DEF,
    parameter int M    = M_DEF,
    parameter int LOGM = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    layer_frame_collector_if.slave    s,
    layer_frame_collector_if.master   m,
    output logic                      max_valid,
    output logic [LOGM-1:0]           max_idx,
    output logic signed [T-1:0]       max_val
);

    localparam logic [LOGM-1:0] LAST_IDX = LOGM'(M - 1);

    collector_state_t    state;
    logic [LOGM-1:0]     wr_idx;
    logic [LOGM-1:0]     rd_idx;
    logic                s_ready_q;
    logic                m_valid_q;
    logic signed [T-1:0] frame_buf [M];
    logic                accept;
    logic                handoff;
    logic                at_last;

    assign accept    = s.valid && s_ready_q;
    assign handoff   = m_valid_q && m.ready;
    assign at_last   = (rd_idx == LAST_IDX);

    assign s.ready   = s_ready_q;
    assign m.valid   = m_valid_q;
    assign max_valid = m_valid_q;
    assign m.last    = m_valid_q && at_last;
    // Gate the buffer so m_data reads zero outside a drain, whatever the buffer holds.
    assign m.data    = m_valid_q ? frame_buf[rd_idx] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= COLLECT;
            wr_idx    <= '0;
            rd_idx    <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    s_ready_q <= 1'b1;
                    m_valid_q <= 1'b0;
                    if (accept) begin
                        if (wr_idx == LAST_IDX) begin
                            wr_idx    <= '0;
                            state     <= DRAIN;
                            s_ready_q <= 1'b0;
                            m_valid_q <= 1'b1;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (handoff) begin
                        if (at_last) begin
                            rd_idx    <= '0;
                            state     <= COLLECT;
                            m_valid_q <= 1'b0;
                            s_ready_q <= 1'b1;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= COLLECT;
                    s_ready_q <= 1'b0;
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            frame_buf[wr_idx] <= s.data;
        end
    end

    frame_argmax #(
        .T    (T),
        .LOGM (LOGM)
    ) u_argmax (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .first   (wr_idx == '0),
        .din     (s.data),
        .idx     (wr_idx),
        .max_val (max_val),
        .max_idx (max_idx)
    );

endmodule

// File: tb/tb_layer_frame_collector.sv
// Directed bench for layer_frame_collector: a frame-level scoreboard plus literal spot checks.
module tb_layer_frame_collector;
    import layer_pkg::*;

    localparam int T    = 9;
    localparam int M    = 5;
    localparam int LOGM = 3;

    logic clk = 1'b0;
    logic reset;

    layer_frame_collector_if #(.T(T)) s_if ();
    layer_frame_collector_if #(.T(T)) m_if ();
    layer_frame_collector_if #(.T(T)) s1_if ();
    layer_frame_collector_if #(.T(T)) m1_if ();

    logic                max_valid, max_valid1;
    logic [LOGM-1:0]     max_idx;
    logic [0:0]          max_idx1;
    logic signed [T-1:0] max_val, max_val1;

    assign s_if.last  = 1'b0;
    assign s1_if.last = 1'b0;

    layer_frame_collector #(.T(T), .M(M), .LOGM(LOGM)) dut (
        .clk       (clk),
        .reset     (reset),
        .s         (s_if),
        .m         (m_if),
        .max_valid (max_valid),
        .max_idx   (max_idx),
        .max_val   (max_val)
    );

    layer_frame_collector #(.T(T), .M(1), .LOGM(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .s         (s1_if),
        .m         (m1_if),
        .max_valid (max_valid1),
        .max_idx   (max_idx1),
        .max_val   (max_val1)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Frame-level model: words accepted upstream, frames awaiting replay, their argmax.
    int cur[$];
    int exp_q[$];
    int exp_mval[$];
    int exp_midx[$];
    int pos = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (s_if.valid && s_if.ready) begin
                cur.push_back(int'(s_if.data));
                if (cur.size() == M) begin
                    int bi;
                    bi = 0;
                    for (int i = 1; i < M; i++) if (cur[i] > cur[bi]) bi = i;
                    exp_mval.push_back(cur[bi]);
                    exp_midx.push_back(bi);
                    foreach (cur[i]) exp_q.push_back(cur[i]);
                    cur.delete();
                end
            end
            chk("ready_valid_exclusive", int'(s_if.ready && m_if.valid), 0);
            chk("max_valid_tracks", int'(max_valid), int'(m_if.valid));
            if (m_if.valid) begin
                chk("sb_nonempty", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk("sb_data", int'(m_if.data), exp_q[0]);
                    chk("sb_last", int'(m_if.last), int'(pos == M - 1));
                    chk("sb_max_val", int'(max_val), exp_mval[0]);
                    chk("sb_max_idx", int'(max_idx), exp_midx[0]);
                    if (m_if.ready) begin
                        void'(exp_q.pop_front());
                        pos++;
                        if (pos == M) begin
                            pos = 0;
                            void'(exp_mval.pop_front());
                            void'(exp_midx.pop_front());
                        end
                    end
                end
            end else begin
                chk("idle_last_low", int'(m_if.last), 0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input int w);
        bit got;
        got = 1'b0;
        s_if.valid = 1'b1;
        s_if.data  = T'(w);
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (s_if.ready) got = 1'b1;
        end
        chk("accept_timeout", int'(got), 1);
        cyc();
        s_if.valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 60 && !idle; i++) begin
            @(negedge clk);
            if (!m_if.valid && s_if.ready) idle = 1'b1;
        end
        chk("drain_timeout", int'(idle), 1);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f1[M]   = '{-2, 7, 3, 7, -1};
        int f2[M]   = '{-5, -3, -9, -3, -4};
        int f3[M]   = '{10, 20, 30, 40, 50};
        int bp[8]   = '{1, 0, 0, 1, 0, 1, 1, 1};
        int bpd[8]  = '{10, 20, 20, 20, 30, 30, 40, 50};
        int f4[M]   = '{100, 0, -256, 255, 1};
        int hs;

        reset = 1'b1;
        s_if.valid = 1'b0;  s_if.data = '0;
        m_if.ready = 1'b1;
        s1_if.valid = 1'b0; s1_if.data = '0;
        m1_if.ready = 1'b1;
        repeat (3) cyc();

        @(negedge clk);
        chk("rst_s_ready", int'(s_if.ready), 0);
        chk("rst_m_valid", int'(m_if.valid), 0);
        chk("rst_m_last", int'(m_if.last), 0);
        chk("rst_max_valid", int'(max_valid), 0);
        chk("rst_max_idx", int'(max_idx), 0);
        chk("rst_max_val", int'(max_val), 0);
        chk("rst_m_data", int'(m_if.data), 0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("s_ready_before_edge", int'(s_if.ready), 0);
        @(negedge clk);
        chk("s_ready_after_edge", int'(s_if.ready), 1);
        cyc();

        // Back-to-back frame with a tied maximum.
        foreach (f1[i]) send_word(f1[i]);
        for (int i = 0; i < M; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("t1_s_ready_drop", int'(s_if.ready), 0);
                chk("t1_max_idx", int'(max_idx), 1);
                chk("t1_max_val", int'(max_val), 7);
            end
            chk("t1_m_valid", int'(m_if.valid), 1);
            chk("t1_data", int'(m_if.data), f1[i]);
            chk("t1_last", int'(m_if.last), int'(i == M - 1));
        end
        @(negedge clk);
        chk("t1_m_valid_fall", int'(m_if.valid), 0);
        chk("t1_s_ready_rise", int'(s_if.ready), 1);
        cyc();

        // All-negative frame: signed compare.
        foreach (f2[i]) send_word(f2[i]);
        @(negedge clk);
        chk("t2_max_idx", int'(max_idx), 1);
        chk("t2_max_val", int'(max_val), -3);
        wait_idle();

        // Downstream backpressure during drain.
        m_if.ready = 1'b0;
        foreach (f3[i]) send_word(f3[i]);
        hs = 0;
        for (int i = 0; i < 8; i++) begin
            m_if.ready = bp[i][0];
            @(negedge clk);
            chk("t3_s_ready_low", int'(s_if.ready), 0);
            chk("t3_data_hold", int'(m_if.data), bpd[i]);
            if (m_if.valid && m_if.ready) hs++;
            cyc();
        end
        chk("t3_handshakes", hs, 5);
        @(negedge clk);
        chk("t3_s_ready_rise", int'(s_if.ready), 1);
        chk("t3_m_valid_fall", int'(m_if.valid), 0);
        cyc();

        // Upstream word presented during drain is held off, then next frame with gaps.
        m_if.ready = 1'b0;
        foreach (f3[i]) send_word(f3[i] + 1);
        s_if.valid = 1'b1;
        s_if.data  = T'(100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_no_accept_ready", int'(s_if.ready), 0);
            chk("t4_drain_valid", int'(m_if.valid), 1);
            chk("t4_no_partial", cur.size(), 0);
            cyc();
        end
        m_if.ready = 1'b1;
        foreach (f4[i]) begin
            send_word(f4[i]);
            if (i < M - 1) repeat ($urandom_range(0, 3)) cyc();
        end
        @(negedge clk);
        chk("t4_max_idx", int'(max_idx), 3);
        chk("t4_max_val", int'(max_val), 255);
        wait_idle();

        // Reset after three accepts discards the partial frame.
        send_word(9);
        send_word(8);
        send_word(7);
        reset = 1'b1;
        cur.delete();
        cyc();
        @(negedge clk);
        chk("t5_s_ready", int'(s_if.ready), 0);
        chk("t5_m_valid", int'(m_if.valid), 0);
        chk("t5_max_val", int'(max_val), 0);
        chk("t5_max_idx", int'(max_idx), 0);
        chk("t5_m_data", int'(m_if.data), 0);
        cyc();
        reset = 1'b0;
        for (int i = 1; i <= M; i++) send_word(i);
        for (int i = 1; i <= M; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("t5_max_idx_new", int'(max_idx), 4);
                chk("t5_max_val_new", int'(max_val), 5);
            end
            chk("t5_data", int'(m_if.data), i);
        end
        wait_idle();

        // Single-word build.
        s1_if.valid = 1'b1;
        s1_if.data  = T'(42);
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (s1_if.ready) got = 1'b1;
            end
            chk("m1_accept_timeout", int'(got), 1);
        end
        cyc();
        s1_if.valid = 1'b0;
        @(negedge clk);
        chk("m1_valid", int'(m1_if.valid), 1);
        chk("m1_last", int'(m1_if.last), 1);
        chk("m1_data", int'(m1_if.data), 42);
        chk("m1_max_idx", int'(max_idx1), 0);
        chk("m1_max_val", int'(max_val1), 42);
        chk("m1_s_ready_low", int'(s1_if.ready), 0);
        @(negedge clk);
        chk("m1_valid_fall", int'(m1_if.valid), 0);
        chk("m1_s_ready_rise", int'(s1_if.ready), 1);

        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/layer_frame_collector.md
Name: layer_frame_collector

Overview:
- Receiver for the serial output stream of a layer_* block, the other end of its m_valid/m_ready/data_out interface.
- Collects one frame of M signed T-bit activations into a local register buffer while tracking the signed maximum and its index (argmax).
- Re-transmits the frame serially, with a last-word flag, to the next layer or to a host.
- Sits between consecutive layers, or at the network output for classification.

Parameters:
- T, 9, data word width (signed, two's complement)
- M, 5, words per frame (number of layer outputs); M >= 1
- LOGM, 3, index width; 2^LOGM >= M

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- s_valid  input  1  upstream word valid (driven by the layer's m_valid)
- s_ready  output  1  collector can accept a word (drives the layer's m_ready)
- s_data  input  T  upstream signed word (driven by the layer's data_out)
- m_valid  output  1  downstream word valid
- m_ready  input  1  downstream accepts the word
- m_data  output  T  downstream signed word
- m_last  output  1  m_data is word M-1 of the frame
- max_valid  output  1  max_idx and max_val describe the current frame
- max_idx  output  LOGM  index of the maximum word
- max_val  output  T  value of the maximum word

Behaviour:
- Reset and clocking:
  - clk is the clock; reset is synchronous, active-high.
  - Reset values: s_ready=0, m_valid=0, m_last=0, max_valid=0, max_idx=0, max_val=0, m_data=0, state=COLLECT, wr_idx=0, rd_idx=0.
  - s_ready rises the first cycle after reset deasserts.
  - Reset mid-frame discards the partial frame; buffer contents are don't-care after reset.
- States: COLLECT, DRAIN. Two-process FSM. All outputs are registered or decoded from registered state only; no combinational path from any input to any output.
- COLLECT:
  - s_ready=1, m_valid=0.
  - An accept is s_valid&&s_ready. On accept: buf[wr_idx]<=s_data and wr_idx increments.
  - Max tracking, signed compare:
    - if wr_idx==0: max_val<=s_data, max_idx<=0
    - else if s_data>max_val: max_val<=s_data, max_idx<=wr_idx
    - ties keep the lower index
  - On accept with wr_idx==M-1: wr_idx<=0, state<=DRAIN.
  - s_valid=0 stalls indefinitely; no timeout.
- DRAIN:
  - s_ready=0, m_valid=1, max_valid=1.
  - m_data=buf[rd_idx], decoded from registered rd_idx with zero added latency.
  - m_last=(rd_idx==M-1).
  - Latency: m_valid and max_valid go high the cycle after the M-th accept.
  - On m_valid&&m_ready: rd_idx increments. No bubble between words while m_ready stays high.
  - On m_valid&&m_ready&&m_last: rd_idx<=0, state<=COLLECT. m_valid, m_last and max_valid fall the next cycle; s_ready rises the same cycle.
  - Stall rule: while m_valid&&!m_ready, m_data, m_last, max_idx and max_val hold stable.
  - Upstream s_valid during DRAIN is ignored (s_ready=0); the layer holds its word.
- Throughput:
  - No overlap between collect and drain; minimum frame period is 2M cycles.
  - s_ready is the upper bound on accepts; s_valid asserted before s_ready is legal.
- M=1 boundary: single accept goes to DRAIN; the only word has m_last=1 and max_idx=0.
- Width rules:
  - Values pass through unmodified; no saturation or rounding.
  - The compare is signed T-bit.
  - Index counters are LOGM wide and wrap explicitly at M-1, not at 2^LOGM.

Decomposition:
- Package layer_pkg:
  - typedef enum logic [0:0] {COLLECT, DRAIN} collector_state_t
  - typedef logic signed [T-1:0] word_t, at the default T
  - localparam defaults T_DEF=9, M_DEF=5
- One natural sub-module, frame_argmax: running signed max/argmax register with clear-on-first, load and hold controls.
- The buffer and FSM stay in the top module.

Test Plan:
- Reset, then feed {-2,7,3,7,-1} back-to-back with m_ready=1:
  - s_ready drops the cycle after the 5th accept.
  - m_data sequence -2,7,3,7,-1 on consecutive cycles, m_last only on -1.
  - max_idx=1, max_val=7 (tie keeps the lower index).
- All-negative frame {-5,-3,-9,-3,-4}: max_idx=1, max_val=-3, checking that the signed compare does not select -9 or 0.
- Downstream backpressure: during drain, toggle m_ready 1,0,0,1,0,1,1,1:
  - m_data holds across stalls.
  - Exactly 5 handshakes occur.
  - s_ready rises only after the handshake that carries m_last.
- Upstream gaps: s_valid with random idle cycles; s_valid asserted during DRAIN is not accepted; the next frame {100,0,-256,255,1} gives max_idx=3, max_val=255.
- Reset mid-frame: assert reset after 3 accepts:
  - All outputs return to 0.
  - A new full frame {1,2,3,4,5} drains as 1..5 with max_idx=4.
  - No stale words appear.
- M=1 build: word 42 gives a single m_valid beat with m_last=1, max_idx=0, max_val=42, then s_ready returns.
